// File: rtl/obsidian_dmem_responder_pkg.sv
// Obsidian data-memory responder: shared types and constants.
// Imported by the interface, array and responder.
package obsidian_dmem_pkg;

  localparam int WORD_W  = 32;
  localparam int LANES   = WORD_W / 8;
  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 15;
  localparam int CNT_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/obsidian_dmem_responder_if.sv
// Request/response handshake bundle for the data-memory responder.
// req_be exists only when OBSIDIAN_DMEM_BYTE_EN is defined.
interface obsidian_dmem_responder_if;
  import obsidian_dmem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [WORD_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
`ifdef OBSIDIAN_DMEM_BYTE_EN
  logic [LANES-1:0]  req_be;
`endif
  logic              resp_valid;
  logic              resp_ready;
  logic [WORD_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
`ifdef OBSIDIAN_DMEM_BYTE_EN
    output req_be,
`endif
    output req_valid,
    output req_write,
    output req_addr,
    output req_wdata,
    output resp_ready,
    input  req_ready,
    input  resp_valid,
    input  resp_rdata,
    input  resp_err
  );

  modport slave (
`ifdef OBSIDIAN_DMEM_BYTE_EN
    input  req_be,
`endif
    input  req_valid,
    input  req_write,
    input  req_addr,
    input  req_wdata,
    input  resp_ready,
    output req_ready,
    output resp_valid,
    output resp_rdata,
    output resp_err
  );

endinterface

// File: rtl/obsidian_dmem_responder_array.sv
// Single-port word RAM with byte lanes and a power-up image.
// On a write, rdata returns the merged word as stored.
module obsidian_dmem_array
  import obsidian_dmem_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [LANES-1:0]  be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // power-up contents; every other word is left undefined
  initial begin
    mem[0]       = 32'hFFFF_FFFF;
    mem[1]       = 32'h0000_0000;
    mem[2]       = 32'hABCD_DCBA;
    mem[3]       = 32'h8765_4321;
    mem[29]      = 32'h1111_1111;
    mem[30]      = 32'h4321_8765;
    mem[31]      = 32'hFEDC_1234;
    mem[34]      = 32'h8888_8888;
    mem[DEPTH-1] = 32'hFFFF_FFFF;
  end

  // lane-wise write-first access on enable
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < LANES; i++) begin
        if (we && be[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
          rdata[8*i +: 8]     <= wdata[8*i +: 8];
        end else begin
          rdata[8*i +: 8]     <= mem[addr][8*i +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/obsidian_dmem_responder.sv
// Obsidian data-memory responder: FSM, latency counter, range check.
// Byte-lane stores are enabled by OBSIDIAN_DMEM_BYTE_EN.
module obsidian_dmem_responder
  import obsidian_dmem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  obsidian_dmem_responder_if.slave  bus
);

  if (LATENCY < LAT_MIN || LATENCY > LAT_MAX) begin : g_lat_chk
    $error("obsidian_dmem_responder: LATENCY out of range");
  end

  localparam bit LAT1 = (LATENCY == 1);

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              req_ready_q;
  logic              err_q;

  logic              lat_write;
  logic [WORD_W-1:0] lat_addr;
  logic [WORD_W-1:0] lat_wdata;
`ifdef OBSIDIAN_DMEM_BYTE_EN
  logic [LANES-1:0]  lat_be;
`endif

  logic              accept;
  logic              commit;
  logic              use_req;
  logic              c_write;
  logic [WORD_W-1:0] c_addr;
  logic [WORD_W-1:0] c_wdata;
  logic [LANES-1:0]  c_be;
  logic              c_err;
  logic [WORD_W-1:0] ram_q;

  assign accept = (state == IDLE)
                & req_ready_q
                & bus.req_valid;

  // state and registered ready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      req_ready_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      req_ready_q <= (state_nxt == IDLE);
    end
  end

  // next-state decode
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = LAT1 ? RESP : WAIT;
      WAIT: if (cnt == CNT_W'(1)) state_nxt = RESP;
      RESP: if (bus.resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // commit strobe and source select for the RESP-entry edge
  always_comb begin
    commit  = 1'b0;
    use_req = 1'b0;
    unique case (1'b1)
      (state == IDLE): begin
        use_req = 1'b1;
        commit  = accept & LAT1;
      end
      (state == WAIT): commit = (cnt == CNT_W'(1));
      default: commit = 1'b0;
    endcase
    c_write = use_req ? bus.req_write : lat_write;
    c_addr  = use_req ? bus.req_addr  : lat_addr;
    c_wdata = use_req ? bus.req_wdata : lat_wdata;
`ifdef OBSIDIAN_DMEM_BYTE_EN
    c_be    = use_req ? bus.req_be    : lat_be;
`else
    c_be    = '1;
`endif
    c_err   = |c_addr[WORD_W-1:ADDR_W];
  end

  // latency counter, loaded on acceptance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= CNT_W'(LATENCY - 1);
    end else if (state == WAIT) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // request capture at acceptance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
`ifdef OBSIDIAN_DMEM_BYTE_EN
      lat_be    <= '0;
`endif
    end else if (accept) begin
      lat_write <= bus.req_write;
      lat_addr  <= bus.req_addr;
      lat_wdata <= bus.req_wdata;
`ifdef OBSIDIAN_DMEM_BYTE_EN
      lat_be    <= bus.req_be;
`endif
    end
  end

  // range-error flag for the pending response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (commit) begin
      err_q <= c_err;
    end
  end

  obsidian_dmem_array #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .en    (commit),
    .we    (commit & c_write & ~c_err),
    .be    (c_be),
    .addr  (c_addr[ADDR_W-1:0]),
    .wdata (c_wdata),
    .rdata (ram_q)
  );

  // ram_q only moves on commit, so it holds through backpressure
  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_err   = (state == RESP) & err_q;
  assign bus.resp_rdata = ((state == RESP) && !err_q)
                        ? ram_q : '0;

endmodule

// File: doc/obsidian_dmem_responder.md
Name: obsidian_dmem_responder

Overview:
- Data-memory responder for the Obsidian pipeline.
- Services the load/store requests issued by the memory stage over a valid/ready request and response handshake.
- Holds the word-addressed data array and returns load data after a fixed, parameterised latency.
- Flags out-of-range addresses instead of aliasing them. One request outstanding at a time.

Parameters:
- DEPTH, 1024, number of 32-bit words in the array.
- ADDR_W, 10, index bits used (DEPTH = 2**ADDR_W).
- LATENCY, 2, cycles from request acceptance to resp_valid. Legal range 1..15.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  word address.
- req_wdata  in  32  store data.
- resp_valid  out  1  response present.
- resp_ready  in  1  requester consumes the response.
- resp_rdata  out  32  load data, or the written word for stores.
- resp_err  out  1  address >= DEPTH.

Behaviour:
- Reset is asynchronous and active-high. While rst=1:
  - state=IDLE, req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, latency counter=0.
  - The array is not cleared.
- req_ready is registered. It goes to 1 on the first clk edge after rst deasserts.
- States:
  - IDLE: req_ready=1. On req_valid&&req_ready, latch write, addr, wdata; load cnt=LATENCY-1; go to WAIT (or straight to RESP when LATENCY=1); req_ready falls.
  - WAIT: cnt decrements each cycle. When cnt==1, the next edge enters RESP.
  - RESP: resp_valid=1. resp_rdata and resp_err are held stable until resp_ready=1. On resp_valid&&resp_ready, return to IDLE; req_ready rises the same edge.
- Latency: resp_valid asserts exactly LATENCY cycles after the acceptance edge. Minimum request-to-request spacing is LATENCY+1 cycles plus any response backpressure.
- Commit point:
  - A store writes the array on the edge that enters RESP.
  - A load samples the array on that same edge, so a load always observes every previously completed store.
- Range check:
  - resp_err=1 when req_addr[31:ADDR_W] != 0.
  - An erroring store does not write the array.
  - An erroring load returns resp_rdata=0.
- Store response: resp_rdata = req_wdata as committed.
- resp_ready=1 while not in RESP is ignored. req_valid while req_ready=0 is ignored; the requester must hold its request.
- Reset mid-operation:
  - A request in WAIT is dropped and its store is not committed.
  - A response in RESP is discarded.
- Power-up image, loaded by an initial block, with all other words undefined:
  - word0=FFFF_FFFF, word1=0000_0000, word2=ABCD_DCBA, word3=8765_4321
  - word29=1111_1111, word30=4321_8765, word31=FEDC_1234, word34=8888_8888
  - word1023=FFFF_FFFF

Optional Feature:
- Macro: OBSIDIAN_DMEM_BYTE_EN.
- Defined:
  - Adds input req_be[3:0], latched at acceptance.
  - A store writes only the lanes with be[i]=1 (lane i = bits 8i+7:8i).
  - The store response returns the merged word as it ends up in the array.
  - req_be=0 on a store leaves memory unchanged but still produces a response.
  - Loads ignore req_be.
- Undefined: the port is absent and every store writes the full word.

Decomposition:
- Package obsidian_dmem_pkg holds:
  - state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2)
  - WORD_W=32
  - the LATENCY legality bounds
- Sub-module obsidian_dmem_array:
  - synchronous single-port RAM with we and optional byte lanes, plus the initial image.
  - The responder holds the FSM, counter, range check and response registers.

Test Plan:
- Reset then load addr 2, LATENCY=2 -> resp_valid exactly 2 cycles after acceptance, resp_rdata=ABCD_DCBA, resp_err=0.
- Store 0x1234_5678 to addr 29, then load 29 -> store response rdata=1234_5678; load returns 1234_5678.
- Load addr 0x400 and store to 0x400 -> resp_err=1, rdata=0. Addr 1023 still reads FFFF_FFFF afterwards.
- Hold resp_ready=0 for 5 cycles in RESP -> resp_valid, rdata and err stay stable; req_ready stays 0; a req_valid pulse is not accepted.
- Store to addr 3, with rst asserted one cycle after acceptance (LATENCY=3) -> all outputs zero asynchronously; a subsequent load of 3 returns 8765_4321.
- With OBSIDIAN_DMEM_BYTE_EN, store AABBCCDD to addr 1 with be=4'b0101 -> response and a later load return 00BB00DD.
